elevator_scheduler: RTL
=======================

Name: elevator_scheduler

Overview:
- Sequencing FSM that owns the car: decides the direction of travel, steps the floor position, times door open/close and travel.
- Emits one-cycle clear pulses back to the latched call-button cells.
- Sits between the button latch instances (car calls, hall up/down calls) and the floor/door outputs of the elevator top level.
- Uses a SCAN policy: keep the current direction while requests lie ahead; otherwise reverse.

Parameters:
- N_FLOORS, 3, number of floors. Bit 0 = lowest floor.
- DOOR_CYCLES, 4, clock cycles the door stays open per stop (>=1).
- MOVE_CYCLES, 8, clock cycles to travel one floor (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- car_call  input  N_FLOORS  latched in-car floor buttons.
- hall_up  input  N_FLOORS  latched hall-up calls. Bit N_FLOORS-1 is ignored.
- hall_down  input  N_FLOORS  latched hall-down calls. Bit 0 is ignored.
- floor  output  N_FLOORS  one-hot current floor.
- door  output  1  1 = door open.
- dir_up  output  1  current direction: 1 = up, 0 = down.
- moving  output  1  1 while in MOVE.
- car_clear  output  N_FLOORS  one-cycle clear pulses for car_call.
- hall_up_clear  output  N_FLOORS  one-cycle clear pulses for hall_up. Top bit tied 0.
- hall_down_clear  output  N_FLOORS  one-cycle clear pulses for hall_down. Bit 0 tied 0.

Behaviour:
- Reset: state = IDLE, floor = one-hot bit 0, door = 0, dir_up = 1, moving = 0, all clears = 0, timer = 0. Reset overrides every state, including mid-MOVE and mid-DOOR_OPEN.
- All outputs are registered.
- "ahead" = any car_call/hall_up/hall_down bit strictly beyond the current floor in dir.
- "behind" = the same test in the opposite direction.
- "here_dir" = car_call[f] | (dir_up ? hall_up[f] : hall_down[f]).
- "here_opp" = the opposite-direction hall call at floor f.
- Stop condition at floor f: here_dir, or (here_opp and not ahead).
  - If the stop is due only to here_opp, dir flips in the same cycle the door opens.
- IDLE:
  - Stop condition true → DOOR_OPEN next cycle.
  - Else if ahead → MOVE next cycle.
  - Else if behind → flip dir, then MOVE.
  - Else stay in IDLE.
- MOVE:
  - moving = 1; timer loads MOVE_CYCLES-1 on entry.
  - On expiry, floor shifts one position in dir (registered), then stop condition is evaluated at the new floor.
  - Stop → DOOR_OPEN. Else ahead → MOVE again (timer reloads). Else → IDLE.
- DOOR_OPEN:
  - door = 1 for exactly DOOR_CYCLES cycles.
  - Each cycle: car_clear[f] = car_call[f]; the hall clear for dir (after any flip) at f = that call bit.
  - Calls at f in the service direction that arrive while the door is open are cleared without restarting the timer. Repeated pulses on an already-clearing bit are harmless.
  - On expiry: ahead → MOVE; else behind → flip dir, then MOVE; else IDLE. door falls the same cycle the state leaves.
- Boundaries:
  - At the top floor dir is forced to 0; at the bottom floor dir is forced to 1.
  - floor never shifts out of range.
  - Requests at the current floor are never cleared outside DOOR_OPEN.
- Clears assert only for bits that are currently set. Clears are never asserted in IDLE or MOVE.
- Simultaneous ahead and behind: the current dir wins.
- Timer width is clog2(max(DOOR_CYCLES, MOVE_CYCLES)). Counts down and saturates at 0.

Decomposition:
- Package elevator_pkg:
  - state enum {IDLE, MOVE, DOOR_OPEN}, 2 bits.
  - DIR_UP / DIR_DOWN constants.
  - Default timing constants.
- Sub-module elevator_timer: loadable down-counter with load, load_value and expired outputs. Shared by MOVE and DOOR_OPEN.
- The mask logic (ahead/behind) stays inline.

Test Plan:
All cases use N_FLOORS = 3, DOOR_CYCLES = 4, MOVE_CYCLES = 8.
1. Reset: assert rst 2 cycles → floor = 3'b001, door = 0, dir_up = 1, all clears 0. Hold quiet 20 cycles → state stays IDLE.
2. Idle at floor 1, car_call = 3'b100:
   - moving rises next cycle; floor = 010 after 8 cycles, with no stop.
   - floor = 100 after 8 more cycles.
   - door = 1 for 4 cycles; car_clear[2] pulses in the first door cycle; then IDLE.
3. Idle at floor 1, hall_up = 3'b001 → door rises next cycle, hall_up_clear[0] pulses, door is high 4 cycles, no movement.
4. Idle at floor 1, car_call[2] and hall_down[1] set:
   - Car passes floor 2 without stopping and stops at floor 3.
   - dir_up goes to 0; car returns and stops at floor 2; hall_down_clear[1] pulses.
5. Car at floor 2, dir up, in IDLE, car_call[0] and car_call[2] set together → goes up first, serves floor 3, then reverses and serves floor 1.
6. Assert rst at cycle 5 of MOVE from floor 1 to floor 2 → next cycle floor = 001, moving = 0, door = 0, no clear pulses.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator scheduler: FSM state encoding,
// direction constants, default timing and the timer width helper.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    DOOR_OPEN = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_N_FLOORS    = 3;
  localparam int DEF_DOOR_CYCLES = 4;
  localparam int DEF_MOVE_CYCLES = 8;

  // Width of the shared door/travel timer; never narrower than one bit.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by the travel and door phases; saturates at 0
// and flags expiry while the count is zero.
module elevator_timer
  import elevator_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (load)          count <= load_value;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-policy car sequencer: chooses direction, steps the one-hot floor,
// times door and travel, and pulses clears back to the call latches.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS    = DEF_N_FLOORS,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES,
  parameter int MOVE_CYCLES = DEF_MOVE_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] car_call,
  input  logic [N_FLOORS-1:0] hall_up,
  input  logic [N_FLOORS-1:0] hall_down,
  output logic [N_FLOORS-1:0] floor,
  output logic                door,
  output logic                dir_up,
  output logic                moving,
  output logic [N_FLOORS-1:0] car_clear,
  output logic [N_FLOORS-1:0] hall_up_clear,
  output logic [N_FLOORS-1:0] hall_down_clear
);

  localparam int TW = timer_width(DOOR_CYCLES, MOVE_CYCLES);
  localparam logic [N_FLOORS-1:0] TOP    = {1'b1, {(N_FLOORS-1){1'b0}}};
  localparam logic [N_FLOORS-1:0] BOTTOM = {{(N_FLOORS-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] DOOR_LOAD = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] MOVE_LOAD = TW'(MOVE_CYCLES - 1);

  state_t              state, state_next;
  logic [N_FLOORS-1:0] floor_next, car_clear_next, hall_up_clear_next, hall_down_clear_next;
  logic                dir_next, door_next, moving_next;
  logic                tmr_load, tmr_expired;
  logic [TW-1:0]       tmr_value;

  logic [N_FLOORS-1:0] hall_up_v, hall_down_v, req, shifted, eval_floor, above, below;
  logic                eval_dir, ahead, behind, here_dir, here_opp, stop, flip_here;

  elevator_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  // Request masks are evaluated at the floor the car is at, or in MOVE at the
  // floor it is about to reach, so arrival decisions take effect on that edge.
  always_comb begin
    hall_up_v   = hall_up & ~TOP;
    hall_down_v = hall_down & ~BOTTOM;
    req         = car_call | hall_up_v | hall_down_v;
    if (dir_up) shifted = (floor == TOP)    ? floor : (floor << 1);
    else        shifted = (floor == BOTTOM) ? floor : (floor >> 1);
    eval_floor  = (state == MOVE) ? shifted : floor;
    eval_dir    = eval_floor[N_FLOORS-1] ? DIR_DOWN : (eval_floor[0] ? DIR_UP : dir_up);
    below       = eval_floor - N_FLOORS'(1);
    above       = ~(eval_floor | below);
    ahead       = |(req & (eval_dir ? above : below));
    behind      = |(req & (eval_dir ? below : above));
    here_dir    = |(eval_floor & (car_call | (eval_dir ? hall_up_v : hall_down_v)));
    here_opp    = |(eval_floor & (eval_dir ? hall_down_v : hall_up_v));
    stop        = here_dir | (here_opp & ~ahead);
    flip_here   = stop & ~here_dir;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      floor           <= BOTTOM;
      dir_up          <= DIR_UP;
      door            <= 1'b0;
      moving          <= 1'b0;
      car_clear       <= '0;
      hall_up_clear   <= '0;
      hall_down_clear <= '0;
    end else begin
      state           <= state_next;
      floor           <= floor_next;
      dir_up          <= dir_next;
      door            <= door_next;
      moving          <= moving_next;
      car_clear       <= car_clear_next;
      hall_up_clear   <= hall_up_clear_next;
      hall_down_clear <= hall_down_clear_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    floor_next = floor;
    dir_next   = dir_up;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    case (state)
      IDLE: begin
        dir_next = eval_dir;
        if (stop) begin
          state_next = DOOR_OPEN;
          dir_next   = eval_dir ^ flip_here;
          tmr_load   = 1'b1;
          tmr_value  = DOOR_LOAD;
        end else if (ahead || behind) begin
          state_next = MOVE;
          dir_next   = ahead ? eval_dir : ~eval_dir;
          tmr_load   = 1'b1;
          tmr_value  = MOVE_LOAD;
        end
      end
      MOVE: begin
        if (tmr_expired) begin
          floor_next = eval_floor;
          dir_next   = eval_dir;
          tmr_load   = 1'b1;
          if (stop) begin
            state_next = DOOR_OPEN;
            dir_next   = eval_dir ^ flip_here;
            tmr_value  = DOOR_LOAD;
          end else if (ahead) begin
            tmr_value  = MOVE_LOAD;
          end else begin
            state_next = IDLE;
            tmr_load   = 1'b0;
          end
        end
      end
      DOOR_OPEN: begin
        if (tmr_expired) begin
          dir_next = eval_dir;
          if (ahead || behind) begin
            state_next = MOVE;
            dir_next   = ahead ? eval_dir : ~eval_dir;
            tmr_load   = 1'b1;
            tmr_value  = MOVE_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A clear is withheld the cycle after it fired, so a latch that drops on
  // that edge sees exactly one pulse.
  always_comb begin
    door_next            = (state_next == DOOR_OPEN);
    moving_next          = (state_next == MOVE);
    car_clear_next       = '0;
    hall_up_clear_next   = '0;
    hall_down_clear_next = '0;
    if (door_next) begin
      car_clear_next = floor_next & car_call & ~car_clear;
      if (dir_next) hall_up_clear_next   = floor_next & hall_up_v & ~hall_up_clear;
      else          hall_down_clear_next = floor_next & hall_down_v & ~hall_down_clear;
    end
  end

endmodule
